// File: rtl/gpu_pkg.sv
// Shape codes and sequencer state encoding shared by the shape sequencer and the
// line/arc datapaths that consume its control strobes.
package gpu_pkg;

  localparam int SHAPE_LINE = 0;
  localparam int SHAPE_TRI  = 1;
  localparam int SHAPE_ARC  = 2;
  localparam int SHAPE_POLY = 3;

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    LOAD,
    DRAW,
    DRAIN,
    ARC_LOAD,
    ARC_STEP,
    ARC_DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/shape_sequencer.sv
// Shape sequencer: steps line segments or arc sweeps, pops the pixel FIFO between them.
// LINE with ldone/fifo_empty high completes 5 cycles after newshape; waitrequest stalls arc steps and pops.
module shape_sequencer
  import gpu_pkg::*;
#(
  parameter int MAX_VERTS  = 8,
  parameter int ARC_PHASES = 8,
  parameter int IDW        = 4,
  localparam int VCW = $clog2(MAX_VERTS + 1),
  localparam int SIW = $clog2(MAX_VERTS),
  localparam int PHW = $clog2(ARC_PHASES)
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           newshape,
  input  logic [IDW-1:0] shapeid,
  input  logic [VCW-1:0] vcount,
  input  logic           ldone,
  input  logic           adone,
  input  logic           waitrequest,
  input  logic           fifo_empty,
  output logic           busy,
  output logic           primsel,
  output logic [SIW-1:0] seg_idx,
  output logic           seg_load,
  output logic           write,
  output logic           enable,
  output logic [PHW-1:0] phase,
  output logic           read,
  output logic           shapedone,
  output logic           err
);

  state_t         state_q, state_d;
  logic [SIW-1:0] seg_idx_q, seg_idx_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [VCW-1:0] nseg_q, nseg_d;
  logic [IDW-1:0] id_q, id_d;
  logic [VCW-1:0] vcount_q, vcount_d;

  logic pop_ok;
  logic last_seg;
  logic poly_ok;

  assign pop_ok   = !fifo_empty && !waitrequest;
  assign last_seg = (VCW'(seg_idx_q) + VCW'(1)) == nseg_q;
  assign poly_ok  = (vcount_q >= VCW'(3)) && (vcount_q <= VCW'(MAX_VERTS));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      seg_idx_q <= '0;
      phase_q   <= '0;
      nseg_q    <= '0;
      id_q      <= '0;
      vcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      phase_q   <= phase_d;
      nseg_q    <= nseg_d;
      id_q      <= id_d;
      vcount_q  <= vcount_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    phase_d   = phase_q;
    nseg_d    = nseg_q;
    id_d      = id_q;
    vcount_d  = vcount_q;
    primsel   = 1'b0;
    seg_load  = 1'b0;
    write     = 1'b0;
    enable    = 1'b0;
    read      = 1'b0;
    shapedone = 1'b0;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        if (newshape) begin
          id_d     = shapeid;
          vcount_d = vcount;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        seg_idx_d = '0;
        if (id_q == IDW'(SHAPE_LINE)) begin
          nseg_d  = VCW'(1);
          state_d = LOAD;
        end else if (id_q == IDW'(SHAPE_TRI)) begin
          nseg_d  = VCW'(3);
          state_d = LOAD;
        end else if (id_q == IDW'(SHAPE_ARC)) begin
          state_d = ARC_LOAD;
        end else if (id_q == IDW'(SHAPE_POLY) && poly_ok) begin
          nseg_d  = vcount_q;
          state_d = LOAD;
        end else begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      LOAD: begin
        seg_load = 1'b1;
        state_d  = DRAW;
      end
      DRAW: begin
        enable = 1'b1;
        if (ldone) state_d = DRAIN;
      end
      DRAIN: begin
        read = pop_ok;
        if (fifo_empty) begin
          if (last_seg) begin
            state_d = DONE;
          end else begin
            seg_idx_d = seg_idx_q + SIW'(1);
            state_d   = LOAD;
          end
        end
      end
      ARC_LOAD: begin
        primsel = 1'b1;
        write   = 1'b1;
        phase_d = '0;
        state_d = ARC_STEP;
      end
      ARC_STEP: begin
        primsel = 1'b1;
        enable  = !waitrequest;
        // adone only counts at the end of a sweep; otherwise the sweep repeats
        if (!waitrequest) begin
          if (phase_q == PHW'(ARC_PHASES - 1)) begin
            if (adone) state_d = ARC_DRAIN;
            else       phase_d = '0;
          end else begin
            phase_d = phase_q + PHW'(1);
          end
        end
      end
      ARC_DRAIN: begin
        primsel = 1'b1;
        read    = pop_ok;
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        shapedone = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign seg_idx = seg_idx_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_shape_sequencer.sv
// Scoreboard bench for shape_sequencer: directed shapes push expected strobes,
// a negedge monitor pops and compares them as the sequencer emits them.
module tb_shape_sequencer;

  localparam int EV_LOAD = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_WR   = 3;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       newshape = 1'b0;
  logic [3:0] shapeid = '0;
  logic [3:0] vcount = '0;
  logic       tb_ldone = 1'b0;
  logic       adone = 1'b0;
  logic       waitrequest = 1'b0;
  logic       tb_empty = 1'b1;
  logic       use_env = 1'b0;
  logic       env_ldone = 1'b0;
  logic       env_empty = 1'b1;
  logic       ldone, fifo_empty;

  logic       busy, primsel, seg_load, write, enable, read, shapedone, err;
  logic [2:0] seg_idx, phase;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int k_last = 0;
  int rd_cnt = 0;
  int en_cnt = 0;
  int ps_cnt = 0;
  ev_t exp_q[$];

  assign ldone      = use_env ? env_ldone : tb_ldone;
  assign fifo_empty = use_env ? env_empty : tb_empty;

  shape_sequencer dut (
    .clk(clk), .nreset(nreset), .newshape(newshape), .shapeid(shapeid),
    .vcount(vcount), .ldone(ldone), .adone(adone), .waitrequest(waitrequest),
    .fifo_empty(fifo_empty), .busy(busy), .primsel(primsel), .seg_idx(seg_idx),
    .seg_load(seg_load), .write(write), .enable(enable), .phase(phase),
    .read(read), .shapedone(shapedone), .err(err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void push(input int kind, input int idx, input int c);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic mon_ev(input int kind, input int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == EV_LOAD) chk("seg_idx", idx, e.idx);
      if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every strobe the sequencer emits must match the head of the queue.
  always @(negedge clk) begin
    if (nreset) begin
      if (seg_load)  mon_ev(EV_LOAD, int'(seg_idx));
      if (shapedone) mon_ev(EV_DONE, 0);
      if (err)       mon_ev(EV_ERR, 0);
      if (write)     mon_ev(EV_WR, 0);
      rd_cnt += int'(read);
      en_cnt += int'(enable);
      ps_cnt += int'(primsel);
    end
  end

  // Reactive line rasteriser / FIFO: 2 words per segment, ldone in the 3rd DRAW cycle.
  int fcnt = 0;
  int dcnt = 0;
  always begin
    logic s_rd, s_sl, s_en;
    @(negedge clk);
    s_rd = read;
    s_sl = seg_load;
    s_en = enable && !primsel;
    @(posedge clk);
    #1;
    if (s_sl) begin
      fcnt = 2;
      dcnt = 0;
    end else begin
      if (s_rd && fcnt > 0) fcnt--;
      if (s_en) dcnt++;
    end
    env_ldone = (dcnt >= 2);
    env_empty = (fcnt == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_shape(input int id, input int vc);
    shapeid  = 4'(id);
    vcount   = 4'(vc);
    newshape = 1'b1;
    k_last   = cyc;
    tick();
    newshape = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  int rd0, en0, ps0, n;

  initial begin
    #2;
    chk("reset_outputs", int'({busy, primsel, seg_idx, seg_load, write, enable,
                               phase, read, shapedone, err}), 0);
    tick();
    nreset = 1'b1;
    tick();

    // LINE: ldone held, FIFO empty -> shapedone exactly 5 cycles after newshape.
    tb_ldone = 1'b1;
    tb_empty = 1'b1;
    start_shape(0, 0);
    push(EV_LOAD, 0, k_last + 2);
    push(EV_DONE, 0, k_last + 5);
    wait_idle(50);

    // POLY with 5 vertices through the reactive rasteriser/FIFO.
    use_env = 1'b1;
    tb_ldone = 1'b0;
    rd0 = rd_cnt;
    start_shape(3, 5);
    for (int i = 0; i < 5; i++) push(EV_LOAD, i, -1);
    push(EV_DONE, 0, -1);
    wait_idle(300);
    chk("poly_reads", rd_cnt - rd0, 10);

    // ARC: 2-cycle stall at phase 3 of sweep 1, adone raised during sweep 2.
    use_env = 1'b0;
    tb_empty = 1'b1;
    en0 = en_cnt;
    ps0 = ps_cnt;
    start_shape(2, 0);
    push(EV_WR, 0, k_last + 2);
    push(EV_DONE, 0, -1);
    n = 0;
    while (!(primsel && enable && phase == 3'd3) && n < 50) begin tick(); n++; end
    chk("arc_reach_phase3", n < 50 ? 1 : 0, 1);
    waitrequest = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_phase", int'(phase), 3);
      chk("stall_enable", int'(enable), 0);
      tick();
    end
    waitrequest = 1'b0;
    n = 0;
    while (!(primsel && enable && phase == 3'd0) && n < 50) begin tick(); n++; end
    chk("arc_sweep2_start", n < 50 ? 1 : 0, 1);
    adone = 1'b1;
    wait_idle(100);
    adone = 1'b0;
    chk("arc_steps", en_cnt - en0, 16);
    chk("arc_primsel_cycles", ps_cnt - ps0, 20);

    // Unsupported code and out-of-range polygon vertex counts.
    for (int t = 0; t < 3; t++) begin
      int ids[3] = '{7, 3, 3};
      int vcs[3] = '{0, 2, 9};
      start_shape(ids[t], vcs[t]);
      push(EV_ERR, 0, k_last + 1);
      chk("err_busy_decode", int'(busy), 1);
      tick();
      chk("err_busy_after", int'(busy), 0);
    end

    // Reset during DRAW of a TRI at segment 1 abandons the shape.
    use_env = 1'b1;
    start_shape(1, 0);
    push(EV_LOAD, 0, -1);
    push(EV_LOAD, 1, -1);
    n = 0;
    while (!(enable && !primsel && seg_idx == 3'd1) && n < 100) begin tick(); n++; end
    chk("tri_reach_seg1", n < 100 ? 1 : 0, 1);
    nreset = 1'b0;
    #1;
    chk("midshape_reset_outputs", int'({busy, primsel, seg_idx, seg_load, write, enable,
                                        phase, read, shapedone, err}), 0);
    tick();
    tick();
    nreset = 1'b1;
    tick();
    chk("reset_queue_drained", exp_q.size(), 0);
    use_env = 1'b0;
    tb_ldone = 1'b1;
    tb_empty = 1'b1;
    start_shape(0, 0);
    push(EV_LOAD, 0, k_last + 2);
    push(EV_DONE, 0, k_last + 5);
    wait_idle(50);

    // newshape pulsed (with a bad code) while drawing a TRI is ignored.
    use_env = 1'b1;
    tb_ldone = 1'b0;
    start_shape(1, 0);
    for (int i = 0; i < 3; i++) push(EV_LOAD, i, -1);
    push(EV_DONE, 0, -1);
    n = 0;
    while (!(enable && !primsel) && n < 50) begin tick(); n++; end
    chk("tri_reach_draw", n < 50 ? 1 : 0, 1);
    start_shape(7, 0);
    wait_idle(300);
    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shape_sequencer.md
SHAPE_SEQUENCER -- requirements
Module: shape_sequencer

Interface
REQ-001 Parameter MAX_VERTS, default 8, meaning the maximum polygon vertex count (at least 3).
REQ-002 Parameter ARC_PHASES, default 8, meaning the number of arc generator phases per sweep (at least 2).
REQ-003 Parameter IDW, default 4, meaning the shape-id width.
REQ-004 Port clk, input, width 1, system clock.
REQ-005 Port nreset, input, width 1, asynchronous active-low reset.
REQ-006 Port newshape, input, width 1, shape request; sampled only in IDLE.
REQ-007 Port shapeid, input, width IDW, shape code.
REQ-008 Port vcount, input, width clog2(MAX_VERTS+1), polygon vertex count.
REQ-009 Port ldone, input, width 1, line rasteriser finished the current segment.
REQ-010 Port adone, input, width 1, arc generator finished the sweep.
REQ-011 Port waitrequest, input, width 1, downstream stall.
REQ-012 Port fifo_empty, input, width 1, pixel FIFO empty.
REQ-013 Port busy, output, width 1, high whenever state is not IDLE.
REQ-014 Port primsel, output, width 1, 0 selects line datapath, 1 selects arc datapath.
REQ-015 Port seg_idx, output, width clog2(MAX_VERTS), current segment index.
REQ-016 Port seg_load, output, width 1, one-cycle endpoint-load strobe.
REQ-017 Port write, output, width 1, one-cycle arc parameter write.
REQ-018 Port enable, output, width 1, rasteriser/arc step enable.
REQ-019 Port phase, output, width clog2(ARC_PHASES), current arc phase.
REQ-020 Port read, output, width 1, FIFO pop.
REQ-021 Port shapedone, output, width 1, one-cycle completion pulse.
REQ-022 Port err, output, width 1, one-cycle pulse on an unsupported shape or bad vcount.

Function
REQ-023 States SHALL be IDLE, DECODE, LOAD, DRAW, DRAIN, ARC_LOAD, ARC_STEP, ARC_DRAIN, DONE; all outputs are 0 unless stated otherwise.
REQ-024 IDLE: when newshape=1, shapeid and vcount SHALL be latched and the next state is DECODE; newshape outside IDLE is ignored.
REQ-025 DECODE: the segment count nseg SHALL be set by shape code:
  - LINE=0: nseg=1, next LOAD.
  - TRI=1: nseg=3, next LOAD.
  - POLY=3: nseg=vcount, next LOAD.
  - ARC=2: next ARC_LOAD.
REQ-026 DECODE: any other code, or POLY with vcount<3 or vcount>MAX_VERTS, SHALL pulse err for one cycle and return to IDLE with no other output.
REQ-027 On entry to LOAD from DECODE, seg_idx SHALL be 0.
REQ-028 LOAD: seg_load=1 for exactly one cycle, then next state DRAW.
REQ-029 DRAW: enable=1; the state SHALL stay in DRAW until ldone=1, then move to DRAIN.
REQ-030 DRAIN and ARC_DRAIN: read=1 only when fifo_empty=0 and waitrequest=0; the state exits on the first cycle fifo_empty=1.
REQ-031 DRAIN exit: if seg_idx==nseg-1, next state DONE; otherwise seg_idx increments and the next state is LOAD.
REQ-032 ARC_LOAD: primsel=1 and write=1 for one cycle, phase cleared to 0, next state ARC_STEP.
REQ-033 ARC_STEP: primsel=1 and enable=!waitrequest; phase advances only when waitrequest=0.
REQ-034 ARC_STEP at phase ARC_PHASES-1 with waitrequest=0: if adone=1, next state ARC_DRAIN; otherwise phase wraps to 0.
REQ-035 primsel SHALL stay at 1 through ARC_DRAIN.
REQ-036 DONE: shapedone=1 for one cycle, then IDLE.
REQ-037 Latency: a LINE shape with ldone already high and fifo_empty=1 SHALL take newshape to shapedone in exactly 5 cycles (DECODE, LOAD, DRAW, DRAIN, DONE).
REQ-038 ldone and adone SHALL be ignored outside DRAW and ARC_STEP respectively.

Reset
REQ-039 With nreset=0, asynchronously: state=IDLE, seg_idx=0, phase=0, nseg=0, latched id and vcount=0.
REQ-040 During reset all outputs SHALL be 0; reset mid-shape abandons the shape with no shapedone pulse.

Structure
REQ-041 Shape codes and the state enum SHALL live in package gpu_pkg, shared with the datapath.
REQ-042 No sub-module is required; segment and phase counters are inline.

Verification
REQ-043 LINE, ldone held 1, fifo_empty=1 -> shapedone exactly 5 cycles after newshape; seg_load pulses once.
REQ-044 POLY, vcount=5, ldone after 3 cycles per segment, FIFO holds 2 words per segment -> seg_load pulses 5 times with seg_idx 0..4, read=10 total, one shapedone.
REQ-045 ARC, ARC_PHASES=8, adone=1 on the second sweep, waitrequest high for 2 cycles mid-sweep -> phase frozen during the stall, 16 enabled steps, then ARC_DRAIN, then shapedone.
REQ-046 shapeid=7, and separately POLY with vcount=2 -> one err pulse each, busy drops after 2 cycles, no seg_load or shapedone.
REQ-047 Reset asserted in DRAW of a TRI at seg_idx=1 -> all outputs 0 immediately; a new LINE after reset completes normally.
REQ-048 newshape pulsed during DRAW -> ignored; exactly one shapedone.
